// File: rtl/wm_input_conditioner_if.sv
// Washing-machine front-panel signal bundle.
// Raw switch inputs, FSM idle status and conditioned outputs.
interface wm_input_conditioner_if;
    logic       start_pause_raw;
    logic       door_sensor_raw;
    logic [1:0] mode_select_raw;
    logic       fsm_idle;
    logic       start_pause_pulse;
    logic       door_closed;
    logic       door_open_event;
    logic [1:0] mode_sel;

    modport master (
        output start_pause_raw,
        output door_sensor_raw,
        output mode_select_raw,
        output fsm_idle,
        input  start_pause_pulse,
        input  door_closed,
        input  door_open_event,
        input  mode_sel
    );

    modport slave (
        input  start_pause_raw,
        input  door_sensor_raw,
        input  mode_select_raw,
        input  fsm_idle,
        output start_pause_pulse,
        output door_closed,
        output door_open_event,
        output mode_sel
    );
endinterface

// File: rtl/wm_input_conditioner.sv
// Synchronizes and debounces the washer panel inputs.
// Button -> press pulse, door -> level + open event, mode -> idle-gated latch.
module wm_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    wm_input_conditioner_if.slave  io
);

    // Last count value before a stable change is accepted.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             btn_s1_q, btn_s2_q;
    logic             door_s1_q, door_s2_q;
    logic [1:0]       mode_s1_q, mode_s2_q;

    logic [CNT_W-1:0] btn_cnt_q, btn_cnt_d;
    logic             btn_lvl_q, btn_lvl_d;
    logic             pulse_q, pulse_d;

    logic [CNT_W-1:0] door_cnt_q, door_cnt_d;
    logic             door_lvl_q, door_lvl_d;
    logic             evt_q, evt_d;

    logic [1:0]       cand_q, cand_d;
    logic [CNT_W-1:0] mode_cnt_q, mode_cnt_d;
    logic [1:0]       mode_sel_q, mode_sel_d;

    // Two-flop synchronizers for every raw input bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1_q  <= 1'b0;
            btn_s2_q  <= 1'b0;
            door_s1_q <= 1'b0;
            door_s2_q <= 1'b0;
            mode_s1_q <= 2'b00;
            mode_s2_q <= 2'b00;
        end else begin
            btn_s1_q  <= io.start_pause_raw;
            btn_s2_q  <= btn_s1_q;
            door_s1_q <= io.door_sensor_raw;
            door_s2_q <= door_s1_q;
            mode_s1_q <= io.mode_select_raw;
            mode_s2_q <= mode_s1_q;
        end
    end

    // Button debouncer: count mismatches, flip level after a full stable run.
    always_comb begin
        btn_cnt_d = btn_cnt_q;
        btn_lvl_d = btn_lvl_q;
        if (btn_s2_q == btn_lvl_q) begin
            btn_cnt_d = '0;
        end else if (btn_cnt_q >= LAST) begin
            btn_lvl_d = ~btn_lvl_q;
            btn_cnt_d = '0;
        end else begin
            btn_cnt_d = btn_cnt_q + ONE;
        end
        pulse_d = btn_lvl_d & ~btn_lvl_q;
    end

    // Door debouncer: same rule, event only on a closed-to-open flip.
    always_comb begin
        door_cnt_d = door_cnt_q;
        door_lvl_d = door_lvl_q;
        if (door_s2_q == door_lvl_q) begin
            door_cnt_d = '0;
        end else if (door_cnt_q >= LAST) begin
            door_lvl_d = ~door_lvl_q;
            door_cnt_d = '0;
        end else begin
            door_cnt_d = door_cnt_q + ONE;
        end
        evt_d = door_lvl_q & ~door_lvl_d;
    end

    // Mode path: track a candidate, load it once stable and the FSM is idle.
    always_comb begin
        cand_d     = cand_q;
        mode_cnt_d = mode_cnt_q;
        mode_sel_d = mode_sel_q;
        if (mode_s2_q != cand_q) begin
            cand_d     = mode_s2_q;
            mode_cnt_d = '0;
        end else begin
            if (mode_cnt_q < LAST) begin
                mode_cnt_d = mode_cnt_q + ONE;
            end
            if (mode_cnt_q >= LAST && io.fsm_idle) begin
                mode_sel_d = cand_q;
            end
        end
    end

    // State registers; reset forces the door open and drops any pending pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_cnt_q  <= '0;
            btn_lvl_q  <= 1'b0;
            pulse_q    <= 1'b0;
            door_cnt_q <= '0;
            door_lvl_q <= 1'b0;
            evt_q      <= 1'b0;
            cand_q     <= 2'b00;
            mode_cnt_q <= '0;
            mode_sel_q <= 2'b00;
        end else begin
            btn_cnt_q  <= btn_cnt_d;
            btn_lvl_q  <= btn_lvl_d;
            pulse_q    <= pulse_d;
            door_cnt_q <= door_cnt_d;
            door_lvl_q <= door_lvl_d;
            evt_q      <= evt_d;
            cand_q     <= cand_d;
            mode_cnt_q <= mode_cnt_d;
            mode_sel_q <= mode_sel_d;
        end
    end

    assign io.start_pause_pulse = pulse_q;
    assign io.door_closed       = door_lvl_q;
    assign io.door_open_event   = evt_q;
    assign io.mode_sel          = mode_sel_q;

endmodule

// File: tb/tb_wm_input_conditioner.sv
// Directed bench for wm_input_conditioner with a pulse scoreboard.
// Expected pulse cycles are queued at stimulus time and popped on output.
module tb_wm_input_conditioner;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;
    int   exp_pulse[$];
    int   exp_evt[$];
    int   mon_e;
    int   p;
    int   r;

    wm_input_conditioner_if io();

    wm_input_conditioner dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every pulse must match the head expected cycle.
    always @(negedge clk) begin
        if (io.start_pause_pulse === 1'b1) begin
            mon_e = -1;
            if (exp_pulse.size() > 0) mon_e = exp_pulse.pop_front();
            checks++;
            assert (cyc === mon_e) else begin
                failures++;
                $error("FAIL start_pause_pulse cycle got=%0d exp=%0d", cyc, mon_e);
            end
        end else if (exp_pulse.size() > 0 && exp_pulse[0] < cyc) begin
            mon_e = exp_pulse.pop_front();
            checks++;
            assert (io.start_pause_pulse === 1'b1) else begin
                failures++;
                $error("FAIL start_pause_pulse missing got=0 exp_cycle=%0d", mon_e);
            end
        end
        if (io.door_open_event === 1'b1) begin
            mon_e = -1;
            if (exp_evt.size() > 0) mon_e = exp_evt.pop_front();
            checks++;
            assert (cyc === mon_e) else begin
                failures++;
                $error("FAIL door_open_event cycle got=%0d exp=%0d", cyc, mon_e);
            end
        end else if (exp_evt.size() > 0 && exp_evt[0] < cyc) begin
            mon_e = exp_evt.pop_front();
            checks++;
            assert (io.door_open_event === 1'b1) else begin
                failures++;
                $error("FAIL door_open_event missing got=0 exp_cycle=%0d", mon_e);
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        io.start_pause_raw = 1'b0;
        io.door_sensor_raw = 1'b1;
        io.mode_select_raw = 2'b00;
        io.fsm_idle        = 1'b1;
        tick(5);

        chk("rst_pulse", {31'd0, io.start_pause_pulse}, 32'd0);
        chk("rst_door",  {31'd0, io.door_closed},       32'd0);
        chk("rst_evt",   {31'd0, io.door_open_event},   32'd0);
        chk("rst_mode",  {30'd0, io.mode_sel},          32'd0);

        // Door held closed through reset closes 18 cycles after release.
        reset = 1'b0;
        r = cyc;
        wait_until(r + 17);
        chk("door_rel_17", {31'd0, io.door_closed}, 32'd0);
        wait_until(r + 18);
        chk("door_rel_18", {31'd0, io.door_closed}, 32'd1);
        chk("door_rel_evt", {31'd0, io.door_open_event}, 32'd0);

        // Bouncing button then a steady press: one pulse.
        for (int i = 0; i < 10; i++) begin
            io.start_pause_raw = (i % 2 == 0);
            tick(3);
        end
        p = cyc;
        io.start_pause_raw = 1'b1;
        exp_pulse.push_back(p + 18);
        tick(100);
        io.start_pause_raw = 1'b0;
        tick(30);

        // Held press, release, press again: two pulses.
        p = cyc;
        io.start_pause_raw = 1'b1;
        exp_pulse.push_back(p + 18);
        tick(50);
        io.start_pause_raw = 1'b0;
        tick(40);
        p = cyc;
        io.start_pause_raw = 1'b1;
        exp_pulse.push_back(p + 18);
        tick(50);
        io.start_pause_raw = 1'b0;
        tick(30);

        // 15-cycle door glitch is rejected.
        io.door_sensor_raw = 1'b0;
        tick(15);
        io.door_sensor_raw = 1'b1;
        tick(30);
        chk("glitch15_door", {31'd0, io.door_closed}, 32'd1);

        // 16-cycle low opens the door with one event, then recloses.
        p = cyc;
        io.door_sensor_raw = 1'b0;
        exp_evt.push_back(p + 18);
        tick(16);
        io.door_sensor_raw = 1'b1;
        wait_until(p + 17);
        chk("open16_pre", {31'd0, io.door_closed}, 32'd1);
        wait_until(p + 18);
        chk("open16_door", {31'd0, io.door_closed}, 32'd0);
        wait_until(p + 33);
        chk("reclose_pre", {31'd0, io.door_closed}, 32'd0);
        wait_until(p + 34);
        chk("reclose_door", {31'd0, io.door_closed}, 32'd1);
        tick(10);

        // Button press and door opening in the same cycle.
        p = cyc;
        io.door_sensor_raw = 1'b0;
        io.start_pause_raw = 1'b1;
        exp_pulse.push_back(p + 18);
        exp_evt.push_back(p + 18);
        wait_until(p + 18);
        chk("simul_door", {31'd0, io.door_closed}, 32'd0);
        io.start_pause_raw = 1'b0;
        io.door_sensor_raw = 1'b1;
        tick(40);
        chk("simul_reclose", {31'd0, io.door_closed}, 32'd1);

        // Mode change held off while the FSM is busy.
        io.fsm_idle = 1'b0;
        io.mode_select_raw = 2'b10;
        tick(40);
        chk("mode_busy", {30'd0, io.mode_sel}, 32'd0);
        io.fsm_idle = 1'b1;
        tick(1);
        chk("mode_idle", {30'd0, io.mode_sel}, 32'd2);

        // Mode change while idle loads after the stability window.
        p = cyc;
        io.mode_select_raw = 2'b01;
        wait_until(p + 18);
        chk("mode_win_pre", {30'd0, io.mode_sel}, 32'd2);
        tick(1);
        chk("mode_win", {30'd0, io.mode_sel}, 32'd1);
        tick(5);

        // Reset in the middle of a button debounce: no pulse.
        io.start_pause_raw = 1'b1;
        tick(10);
        reset = 1'b1;
        tick(1);
        chk("midrst_pulse", {31'd0, io.start_pause_pulse}, 32'd0);
        chk("midrst_door",  {31'd0, io.door_closed},       32'd0);
        chk("midrst_evt",   {31'd0, io.door_open_event},   32'd0);
        chk("midrst_mode",  {30'd0, io.mode_sel},          32'd0);
        io.start_pause_raw = 1'b0;
        tick(2);
        reset = 1'b0;
        r = cyc;
        wait_until(r + 17);
        chk("midrst_door_17", {31'd0, io.door_closed}, 32'd0);
        wait_until(r + 18);
        chk("midrst_door_18", {31'd0, io.door_closed}, 32'd1);
        tick(30);

        chk("pulse_q_empty", exp_pulse.size(), 32'd0);
        chk("evt_q_empty",   exp_evt.size(),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wm_input_conditioner.md
WM_INPUT_CONDITIONER -- requirements
Module: wm_input_conditioner

Interface
REQ-001 The block SHALL have the parameter DEBOUNCE_CYCLES, default 16, meaning the consecutive stable synchronized cycles required to accept a level change (legal range 2..65535).
REQ-002 The block SHALL have the parameter CNT_W, default 16, meaning the debounce counter width, with 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have the port start_pause_raw, input, 1 bit: the asynchronous, bouncy start/pause pushbutton, 1 = pressed.
REQ-006 The block SHALL have the port door_sensor_raw, input, 1 bit: the asynchronous, bouncy door switch, 1 = closed.
REQ-007 The block SHALL have the port mode_select_raw, input, 2 bits: the asynchronous mode switches (00 normal, 01 delicate, 10 heavy, 11 rinse-only).
REQ-008 The block SHALL have the port fsm_idle, input, 1 bit: from the downstream cycle FSM, high while it is in IDLE or COMPLETE.
REQ-009 The block SHALL have the port start_pause_pulse, output, 1 bit: a one-cycle pulse per accepted button press, feeding the FSM start_pause.
REQ-010 The block SHALL have the port door_closed, output, 1 bit: the debounced door level, feeding the FSM door_sensor.
REQ-011 The block SHALL have the port door_open_event, output, 1 bit: a one-cycle pulse on each debounced closed->open transition.
REQ-012 The block SHALL have the port mode_sel, output, 2 bits: the latched mode, feeding the FSM mode_select.

Function
REQ-013 Each raw input bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Button and door SHALL each use an independent debouncer: a CNT_W counter plus a debounced-level register.
REQ-015 Debouncer rule: when the sync value equals the debounced level, the counter SHALL clear to 0.
REQ-016 Debouncer rule: when the sync value differs from the debounced level, the counter SHALL increment, and on the edge where it reaches DEBOUNCE_CYCLES-1 the debounced level SHALL flip and the counter SHALL clear.
REQ-017 Any single-cycle return of the sync value to the debounced level SHALL restart the count; glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no output change.
REQ-018 Latency from the first clk edge sampling a clean raw change to the debounced level change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-019 start_pause_pulse SHALL be registered and high for exactly one cycle, on the same edge the debounced button level goes 0->1.
REQ-020 Holding the button SHALL yield exactly one pulse; the next pulse requires a debounced release (1->0) and then a new press.
REQ-021 door_closed SHALL equal the debounced door level.
REQ-022 door_open_event SHALL pulse for one cycle on the edge door_closed goes 1->0; no pulse SHALL occur on 0->1 or out of reset.
REQ-023 The mode path SHALL be a 2-bit, 2-flop synchronizer followed by a candidate register and a stability counter; mode_sel SHALL load the candidate only when the candidate is unchanged for DEBOUNCE_CYCLES cycles AND fsm_idle=1.
REQ-024 While fsm_idle=0, mode_sel SHALL hold; a stable new mode SHALL load on the first idle cycle after stability.
REQ-025 Counters SHALL saturate and never wrap; simultaneous button and door events SHALL be processed independently in the same cycle.

Reset
REQ-026 While reset=1, all synchronizer flops, counters and the button debounced level SHALL clear to 0.
REQ-027 While reset=1, the door debounced level SHALL be 0 (treated as open), so a closed door is reported only 2 + DEBOUNCE_CYCLES cycles after reset release.
REQ-028 While reset=1, outputs SHALL be start_pause_pulse=0, door_closed=0, door_open_event=0, mode_sel=00.
REQ-029 Reset asserted mid-count SHALL abort the count, and no pulse SHALL be emitted on reset entry or exit.

Verification
REQ-030 Reset scenario: with DEBOUNCE_CYCLES=16 and door_sensor_raw=1 held through reset, release reset -> door_closed rises exactly 18 cycles later, and door_open_event stays 0.
REQ-031 Bounce scenario: start_pause_raw toggles every 3 cycles for 30 cycles, then holds 1 for 100 cycles -> exactly one start_pause_pulse, 18 cycles after the final rising sample.
REQ-032 Glitch-rejection scenario: a door_sensor_raw low glitch of 15 cycles while closed -> door_closed stays 1 with no event; a 16-cycle low -> door_closed=0 plus a one-cycle door_open_event.
REQ-033 Mode-gating scenario: with fsm_idle=0, change mode_select_raw 00->10 -> mode_sel stays 00; raise fsm_idle -> mode_sel=10 on the next edge.
REQ-034 Re-press scenario: press held 50 cycles, released 40 cycles, pressed again -> exactly two pulses.
REQ-035 Reset-mid-count scenario: assert reset 10 cycles into a button debounce -> no pulse, and all outputs at reset values the cycle after reset is sampled.
